// File: rtl/hd44780_lcd_writer.sv
// HD44780 write engine: buffers {nyb_only, rs, byte} writes in a small FIFO and
// produces the E-cycle timing and post-write execution delay on a 4- or 8-bit bus.
module hd44780_lcd_writer #(
  parameter int BUS_WIDTH       = 4,
  parameter int FIFO_DEPTH      = 4,
  parameter int TICKS_TAS       = 3,
  parameter int TICKS_PWEH      = 22,
  parameter int TICKS_TCYCE     = 48,
  parameter int TICKS_EXEC      = 2544,
  parameter int TICKS_EXEC_LONG = 72960,
  parameter int CNT_BITS        = 17
) (
  input  logic                 CLK_I,
  input  logic                 RST_I,
  input  logic                 STB_I,
  input  logic                 i_rs,
  input  logic [7:0]           i_data,
  input  logic                 i_nyb_only,
  output logic                 o_full,
  output logic                 o_overflow,
  output logic                 o_busy,
  output logic                 o_rs,
  output logic [BUS_WIDTH-1:0] o_lcd_data,
  output logic                 o_e
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam int TICKS_ELO = TICKS_TCYCE - TICKS_TAS - TICKS_PWEH;
  localparam bit MODE4 = (BUS_WIDTH == 4);

  localparam logic [CNT_BITS-1:0] LIM_TAS  = CNT_BITS'(TICKS_TAS - 1);
  localparam logic [CNT_BITS-1:0] LIM_PWEH = CNT_BITS'(TICKS_PWEH - 1);
  localparam logic [CNT_BITS-1:0] LIM_ELO  = CNT_BITS'(TICKS_ELO - 1);
  localparam logic [CNT_BITS-1:0] LIM_EXEC = CNT_BITS'(TICKS_EXEC - 1);
  localparam logic [CNT_BITS-1:0] LIM_LONG = CNT_BITS'(TICKS_EXEC_LONG - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_SETUP, S_EHI, S_ELO, S_EXEC
  } state_t;

  state_t state;

  logic [9:0]    mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count, count_nx;
  logic          empty_q;
  logic          push, pop;

  assign push = STB_I & ~o_full;
  assign pop  = (state == S_IDLE) & ~empty_q;

  always_comb begin
    count_nx = count;
    case ({push, pop})
      2'b10:   count_nx = count + 1'b1;
      2'b01:   count_nx = count - 1'b1;
      default: count_nx = count;
    endcase
  end

  always_ff @(posedge CLK_I) begin
    if (push) mem[wr_ptr] <= {i_nyb_only, i_rs, i_data};
  end

  always_ff @(posedge CLK_I or negedge RST_I) begin
    if (!RST_I) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      empty_q    <= 1'b1;
      o_full     <= 1'b0;
      o_overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count      <= count_nx;
      o_full     <= (count_nx == CW'(FIFO_DEPTH));
      empty_q    <= (count_nx == '0);
      o_overflow <= STB_I & o_full;
    end
  end

  assign o_busy = ~empty_q | (state != S_IDLE);

  logic                 sh_nyb, sh_rs, sh_lo;
  logic [7:0]           sh_data;
  logic [CNT_BITS-1:0]  cnt;
  logic [BUS_WIDTH-1:0] hi_bus, lo_bus;
  logic                 long_exec, last_nyb;
  logic [CNT_BITS-1:0]  exec_lim;

  if (BUS_WIDTH == 8) begin : g_bus8
    assign hi_bus = sh_data;
    assign lo_bus = sh_data;
  end else begin : g_bus4
    assign hi_bus = sh_data[7:4];
    assign lo_bus = sh_data[3:0];
  end

  // Clear display / return home (rs=0, 0x01..0x03) need the long delay.
  assign long_exec = ~sh_rs & (sh_data[7:2] == '0) & (sh_data[1:0] != 2'b00)
                   & ~(MODE4 & sh_nyb);
  assign exec_lim  = long_exec ? LIM_LONG : LIM_EXEC;
  assign last_nyb  = ~MODE4 | sh_nyb | sh_lo;

  always_ff @(posedge CLK_I or negedge RST_I) begin
    if (!RST_I) begin
      state      <= S_IDLE;
      cnt        <= '0;
      sh_nyb     <= 1'b0;
      sh_rs      <= 1'b0;
      sh_lo      <= 1'b0;
      sh_data    <= '0;
      o_rs       <= 1'b0;
      o_lcd_data <= '0;
      o_e        <= 1'b0;
    end else begin
      // E is registered from the phase, so it trails the EHI state by one clock.
      o_e <= (state == S_EHI);
      case (state)
        S_IDLE: begin
          if (!empty_q) begin
            {sh_nyb, sh_rs, sh_data} <= mem[rd_ptr];
            sh_lo <= 1'b0;
            state <= S_LOAD;
          end
        end
        S_LOAD: begin
          o_rs       <= sh_rs;
          o_lcd_data <= hi_bus;
          cnt        <= '0;
          state      <= S_SETUP;
        end
        S_SETUP: begin
          if (cnt == LIM_TAS) begin
            cnt   <= '0;
            state <= S_EHI;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_EHI: begin
          if (cnt == LIM_PWEH) begin
            cnt   <= '0;
            state <= S_ELO;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_ELO: begin
          if (cnt == LIM_ELO) begin
            cnt <= '0;
            if (!last_nyb) begin
              o_lcd_data <= lo_bus;
              sh_lo      <= 1'b1;
              state      <= S_SETUP;
            end else begin
              state <= S_EXEC;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_EXEC: begin
          if (cnt == exec_lim) begin
            cnt   <= '0;
            state <= S_IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          cnt   <= '0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hd44780_lcd_writer.sv
// Randomized bench for hd44780_lcd_writer: a transaction-level timing model predicts
// every E pulse, busy/full/overflow flag, for a 4-bit and an 8-bit instance.
module tb_hd44780_lcd_writer;

  localparam int TAS = 2, PWEH = 4, TCYCE = 10, EXEC = 20, LONG = 50, DEPTH = 4;
  localparam int NE = 128, NP = 256;

  logic       clk = 1'b0, rst_n = 1'b0;
  logic       stb4 = 1'b0, stb8 = 1'b0, rs = 1'b0, nyb = 1'b0;
  logic [7:0] data = '0;
  logic       full4, ovf4, busy4, rs4, e4;
  logic [3:0] d4;
  logic       full8, ovf8, busy8, rs8, e8;
  logic [7:0] d8;

  always #5 clk = ~clk;

  hd44780_lcd_writer #(
    .BUS_WIDTH(4), .FIFO_DEPTH(DEPTH), .TICKS_TAS(TAS), .TICKS_PWEH(PWEH),
    .TICKS_TCYCE(TCYCE), .TICKS_EXEC(EXEC), .TICKS_EXEC_LONG(LONG), .CNT_BITS(17)
  ) dut4 (
    .CLK_I(clk), .RST_I(rst_n), .STB_I(stb4), .i_rs(rs), .i_data(data),
    .i_nyb_only(nyb), .o_full(full4), .o_overflow(ovf4), .o_busy(busy4),
    .o_rs(rs4), .o_lcd_data(d4), .o_e(e4)
  );

  hd44780_lcd_writer #(
    .BUS_WIDTH(8), .FIFO_DEPTH(DEPTH), .TICKS_TAS(TAS), .TICKS_PWEH(PWEH),
    .TICKS_TCYCE(TCYCE), .TICKS_EXEC(EXEC), .TICKS_EXEC_LONG(LONG), .CNT_BITS(17)
  ) dut8 (
    .CLK_I(clk), .RST_I(rst_n), .STB_I(stb8), .i_rs(rs), .i_data(data),
    .i_nyb_only(nyb), .o_full(full8), .o_overflow(ovf8), .o_busy(busy8),
    .o_rs(rs8), .o_lcd_data(d8), .o_e(e8)
  );

  int checks = 0, errors = 0;
  int c = 0;

  // Per instance (0: 4-bit, 1: 8-bit): accepted writes and their expected E pulses.
  int push_t[2][NE], pop_t[2][NE], end_t[2][NE];
  int n_acc[2], last_end[2], ov_edge[2];
  int pr_t[2][NP], pr_d[2][NP], pr_rs[2][NP];
  int n_exp[2], n_seen[2];
  int prev_e[2], hi_cnt[2], cur_d[2], cur_rs[2];

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h want %0h", tag, c, act, exp);
    end
  endtask

  function automatic int occ(input int m, input int t);
    int n = 0;
    for (int k = 0; k < n_acc[m]; k++)
      if (push_t[m][k] <= t && pop_t[m][k] > t) n++;
    return n;
  endfunction

  function automatic bit busy_exp(input int m, input int t);
    for (int k = 0; k < n_acc[m]; k++)
      if (push_t[m][k] <= t && t < end_t[m][k]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      n_acc[m] = 0; last_end[m] = -100; ov_edge[m] = -1;
      n_exp[m] = 0; n_seen[m] = 0; prev_e[m] = 0; hi_cnt[m] = 0;
    end
  endtask

  // A write pushed at edge e is popped at the first free IDLE edge, then each
  // nybble/byte occupies TCYCE clocks and the execution delay follows.
  task automatic model_push(input int m, input bit r, input logic [7:0] d, input bit n);
    int e, p, nn, ex, k;
    e = c + 1;
    if (occ(m, c) >= DEPTH || n_acc[m] >= NE) begin
      ov_edge[m] = e;
      return;
    end
    k  = n_acc[m];
    p  = (e + 1 > last_end[m] + 1) ? e + 1 : last_end[m] + 1;
    nn = (m == 0 && !n) ? 2 : 1;
    for (int j = 0; j < nn; j++) begin
      if (n_exp[m] < NP) begin
        pr_t[m][n_exp[m]]  = p + 2 + TAS + j * TCYCE;
        pr_d[m][n_exp[m]]  = (m == 1) ? int'(d) : (j == 0 ? int'(d[7:4]) : int'(d[3:0]));
        pr_rs[m][n_exp[m]] = int'(r);
        n_exp[m]++;
      end
    end
    ex = (!r && d >= 1 && d <= 3 && !(m == 0 && n)) ? LONG : EXEC;
    push_t[m][k] = e;
    pop_t[m][k]  = p;
    end_t[m][k]  = p + 1 + nn * TCYCE + ex;
    last_end[m]  = end_t[m][k];
    n_acc[m]++;
  endtask

  task automatic observe(input int m, input logic e, input logic [7:0] d, input logic r,
                         input logic b, input logic f, input logic o);
    check(m == 0 ? "busy4" : "busy8", b, busy_exp(m, c));
    check(m == 0 ? "full4" : "full8", f, occ(m, c) == DEPTH);
    check(m == 0 ? "ovf4" : "ovf8", o, ov_edge[m] == c);
    if (e && !prev_e[m]) begin
      if (n_seen[m] < n_exp[m]) begin
        check("e_rise_cycle", c, pr_t[m][n_seen[m]]);
        check("e_data", d, pr_d[m][n_seen[m]]);
        check("e_rs", r, pr_rs[m][n_seen[m]]);
        cur_d[m]  = pr_d[m][n_seen[m]];
        cur_rs[m] = pr_rs[m][n_seen[m]];
        n_seen[m]++;
      end else begin
        check("e_extra", n_seen[m] + 1, n_exp[m]);
      end
      hi_cnt[m] = 1;
    end else if (e) begin
      hi_cnt[m]++;
      check("hold_data", d, cur_d[m]);
      check("hold_rs", r, cur_rs[m]);
    end else if (prev_e[m] != 0) begin
      check("e_width", hi_cnt[m], PWEH);
    end
    prev_e[m] = int'(e);
  endtask

  task automatic step(input bit s4, input bit s8, input bit r, input logic [7:0] d, input bit n);
    stb4 = s4; stb8 = s8; rs = r; data = d; nyb = n;
    if (rst_n) begin
      if (s4) model_push(0, r, d, n);
      if (s8) model_push(1, r, d, n);
    end
    @(negedge clk);
    c++;
    stb4 = 1'b0; stb8 = 1'b0;
    observe(0, e4, {4'b0000, d4}, rs4, busy4, full4, ovf4);
    observe(1, e8, d8, rs8, busy8, full8, ovf8);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic wait_quiet();
    for (int i = 0; i < 5000 && (busy_exp(0, c) || busy_exp(1, c)); i++) idle(1);
    idle(3);
  endtask

  initial begin
    logic [7:0] rd;
    bit         rr, rn;
    model_reset();
    repeat (3) @(negedge clk);
    check("rst_e", {e4, e8}, 0);
    check("rst_rs", {rs4, rs8}, 0);
    check("rst_data", {d4, d8}, 0);
    check("rst_flags", {busy4, full4, ovf4, busy8, full8, ovf8}, 0);
    rst_n = 1'b1;
    c = 0;
    idle(2);

    // Data write on the 4-bit bus: two nybbles.
    step(1'b1, 1'b0, 1'b1, 8'hA5, 1'b0);
    wait_quiet();
    // Clear display (long delay) followed by entry mode (short delay).
    step(1'b1, 1'b0, 1'b0, 8'h01, 1'b0);
    step(1'b1, 1'b0, 1'b0, 8'h06, 1'b0);
    wait_quiet();
    // Single-nybble init write.
    step(1'b1, 1'b0, 1'b0, 8'h30, 1'b1);
    wait_quiet();
    // Fill the FIFO behind an in-flight write; the fifth push is refused.
    step(1'b1, 1'b0, 1'b1, 8'h5A, 1'b0);
    idle(3);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b1, 8'h10 + 8'(i), 1'b0);
    wait_quiet();

    // Random bursts with mixed gaps, commands and nybble-only writes.
    for (int i = 0; i < 40; i++) begin
      rr = 1'($urandom_range(0, 1));
      rd = 8'($urandom);
      rn = ($urandom_range(0, 4) == 0);
      if ($urandom_range(0, 3) == 0) begin
        rr = 1'b0;
        rd = 8'($urandom_range(1, 3));
      end
      step(1'b1, 1'b0, rr, rd, rn);
      idle(($urandom_range(0, 5) == 0) ? int'($urandom_range(10, 80)) : int'($urandom_range(0, 3)));
    end
    wait_quiet();

    // Reset while E is high abandons the transfer and empties the FIFO.
    step(1'b1, 1'b0, 1'b1, 8'hC3, 1'b0);
    step(1'b1, 1'b0, 1'b0, 8'h01, 1'b0);
    step(1'b1, 1'b0, 1'b1, 8'h7E, 1'b0);
    for (int k = 0; k < 50 && e4 !== 1'b1; k++) idle(1);
    check("ehi_reached", e4, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_e", e4, 1'b0);
    check("async_rst_busy", busy4, 1'b0);
    check("async_rst_full", full4, 1'b0);
    model_reset();
    idle(3);
    rst_n = 1'b1;
    idle(100);

    // 8-bit instance: whole bytes, one E pulse each.
    step(1'b0, 1'b1, 1'b1, 8'h48, 1'b0);
    wait_quiet();
    for (int i = 0; i < 8; i++) begin
      rd = (i % 3 == 0) ? 8'($urandom_range(1, 3)) : 8'($urandom);
      step(1'b0, 1'b1, (i % 3 == 0) ? 1'b0 : 1'($urandom_range(0, 1)), rd,
           1'($urandom_range(0, 1)));
      idle(int'($urandom_range(0, 2)));
    end
    wait_quiet();

    check("pulses4_all_seen", n_seen[0], n_exp[0]);
    check("pulses8_all_seen", n_seen[1], n_exp[1]);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hd44780_lcd_writer.md
Name: hd44780_lcd_writer

Overview:
- Parametrised successor to the byte-level LCD sender.
- Accepts {rs, byte} writes through a small FIFO.
- Generates the full HD44780 E-cycle timing internally for a 4-bit or 8-bit bus, including single-nybble writes used by the init sequence.
- Enforces the post-write execution delay (short or long, chosen per command) so the upstream sequencer can burst writes without pacing them.
- Sits between the init/command sequencer and the LCD pins.

Parameters:
- BUS_WIDTH, 4, LCD data bus width; legal values 4 or 8.
- FIFO_DEPTH, 4, write FIFO entries; power of 2, at least 2.
- TICKS_TAS, 3, clocks that RS/data are stable before E rises.
- TICKS_PWEH, 22, clocks E is held high.
- TICKS_TCYCE, 48, total clocks per E cycle; must be ≥ TICKS_TAS + TICKS_PWEH + 1.
- TICKS_EXEC, 2544, clocks of post-write delay for normal writes (53 us at 48 MHz).
- TICKS_EXEC_LONG, 72960, clocks of post-write delay for clear/home (1.52 ms).
- CNT_BITS, 17, timer width; must hold TICKS_EXEC_LONG.

Ports:
- CLK_I  in  1  system clock
- RST_I  in  1  reset; asynchronous, active-low
- STB_I  in  1  write strobe; one entry pushed per cycle high while not o_full
- i_rs  in  1  register select for the entry
- i_data  in  8  byte for the entry
- i_nyb_only  in  1  4-bit mode only: send i_data[7:4] as a single nybble
- o_full  out  1  FIFO full; pushes are refused
- o_overflow  out  1  one-cycle pulse when STB_I is high while o_full
- o_busy  out  1  FIFO non-empty OR FSM not IDLE
- o_rs  out  1  LCD RS pin
- o_lcd_data  out  BUS_WIDTH  LCD data pins (D7..D4 in 4-bit mode)
- o_e  out  1  LCD E pin

Behaviour:
- Reset (RST_I low): takes effect immediately and asynchronously.
  - All outputs go to 0; FIFO is emptied; FSM returns to IDLE; timers are cleared.
  - A transfer in progress is abandoned: E drops at once and the transfer does not resume.
- FIFO push:
  - Entry is {nyb_only, rs, data}; it is written on a rising edge with STB_I high and o_full low.
  - o_full and the empty flag are registered from the occupancy count.
  - A push is refused while o_full is high, even if a pop happens in the same cycle; the refused cycle pulses o_overflow.
  - Push and pop in the same cycle leave the count unchanged. Pointers wrap modulo FIFO_DEPTH.
- FSM states: IDLE, LOAD, SETUP, EHI, ELO, EXEC.
- IDLE:
  - If the FIFO is non-empty, pop the head into shadow registers and go to LOAD.
  - Otherwise hold o_e=0; o_rs and o_lcd_data keep their last values.
- LOAD:
  - Drive o_rs = shadow rs.
  - Drive o_lcd_data = shadow[7:4] in 4-bit mode, or shadow[7:0] in 8-bit mode.
  - Clear the phase counter; go to SETUP.
- SETUP: o_e=0 for TICKS_TAS clocks, then go to EHI.
- EHI: o_e=1 for TICKS_PWEH clocks, then go to ELO.
- ELO:
  - o_e=0 for TICKS_TCYCE − TICKS_TAS − TICKS_PWEH clocks. One nybble or byte therefore takes exactly TICKS_TCYCE clocks from SETUP entry.
  - o_rs and o_lcd_data are stable from LOAD until ELO ends.
  - On exit in 4-bit mode, first nybble, nyb_only=0: drive o_lcd_data = shadow[3:0] and go to SETUP. RS is unchanged.
  - On exit otherwise: go to EXEC.
- EXEC:
  - o_e=0. Wait TICKS_EXEC_LONG clocks if rs=0 and data ∈ {0x01, 0x02, 0x03}; otherwise wait TICKS_EXEC clocks.
  - A nyb_only write always uses TICKS_EXEC.
  - Then go to IDLE. Back-to-back entries therefore cost one IDLE cycle plus one LOAD cycle of gap.
- In 8-bit mode, i_nyb_only is ignored (stored, not used).
- Latency: a push into an empty FIFO with the FSM in IDLE at edge N gives IDLE pop at N+1, LOAD at N+2, SETUP from N+3, and o_e rising at edge N+3+TICKS_TAS.
- o_busy stays high from the cycle after a push until EXEC completes and the FIFO is empty.
- Counter arithmetic is unsigned CNT_BITS; each phase compares against (ticks − 1).
- Any illegal state encoding recovers to IDLE.

Test Plan:
Bench parameters: TAS=2, PWEH=4, TCYCE=10, EXEC=20, EXEC_LONG=50, DEPTH=4, BUS_WIDTH=4.
- Reset release, then push rs=1, data=0xA5 → o_lcd_data=0xA then 0x5; o_rs=1; two o_e pulses of 4 clocks each, 10 clocks apart; first o_e rise 5 edges after the push; o_busy drops 20 clocks after the second ELO ends.
- Push rs=0, data=0x01, then rs=0, data=0x06 → first write waits 50 clocks in EXEC, second waits 20; data never changes while o_e=1.
- Push rs=0, data=0x30 with i_nyb_only=1 → exactly one o_e pulse carrying 0x3; EXEC=20.
- Five pushes on consecutive cycles → o_full asserts after the 4th push; 5th push gives an o_overflow pulse and is dropped; 4 writes emerge in order.
- Drive RST_I low during EHI → o_e=0 in the same cycle; FIFO empties; o_busy=0; after release, no o_e activity until a new push.
- BUS_WIDTH=8, push rs=1, data=0x48 → single o_e pulse with o_lcd_data=0x48; EXEC=20.
